// File: rtl/lfsr_req_arbiter_pkg.sv
// Shared LFSR definitions: arbiter FSM state type and the feedback tap tables.
// LFSR_TAPS[w] is a feedback mask: bit i set means state bit i enters the XOR
// that is shifted in at bit 0 (shift-left Fibonacci form). A width with
// LFSR_N_TAPS[w] == 0 has no entry and is rejected at elaboration.
package lfsr_package;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        SERVE  = 1'b1
    } lfsr_arb_state_t;

    localparam int LFSR_MAX_N = 32;

    localparam int unsigned LFSR_N_TAPS [0:LFSR_MAX_N] = '{
        4: 2, 5: 2, 7: 2, 8: 4, 16: 4, 24: 4, 32: 4,
        default: 0
    };

    // x^4+x^3+1, x^5+x^3+1, x^7+x^6+1, x^8+x^6+x^5+x^4+1,
    // x^16+x^14+x^13+x^11+1, x^24+x^23+x^22+x^17+1, x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS [0:LFSR_MAX_N] = '{
        4:  32'h0000_0009,
        5:  32'h0000_0012,
        7:  32'h0000_0041,
        8:  32'h0000_008E,
        16: 32'h0000_8016,
        24: 32'h0080_0043,
        32: 32'hE000_0200,
        default: 32'h0000_0000
    };

    function automatic bit lfsr_width_ok(input int w);
        if (w < 2 || w > LFSR_MAX_N) begin
            return 1'b0;
        end
        return LFSR_N_TAPS[w] != 0;
    endfunction

endpackage

// File: rtl/lfsr_req_arbiter_if.sv
// Requester-side bus of the shared LFSR arbiter.
// With LFSR_ARB_GRANT_CNT_EN defined the bus also carries grant_cnt.
interface lfsr_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int n     = 16
) ();

    logic             resync;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [n-1:0]     data;
    logic             busy;
`ifdef LFSR_ARB_GRANT_CNT_EN
    logic [31:0]      grant_cnt;

    modport master (output resync, output req, input ack, input data, input busy, input grant_cnt);
    modport slave  (input resync, input req, output ack, output data, output busy, output grant_cnt);
`else
    modport master (output resync, output req, input ack, input data, input busy);
    modport slave  (input resync, input req, output ack, output data, output busy);
`endif

endinterface

// File: rtl/lfsr_cke.sv
// Clock-enabled shift-left Fibonacci LFSR; rst (active-high, asynchronous)
// loads the seed, cke advances one step.
module lfsr_cke #(
    parameter int           n    = 16,
    parameter logic [n-1:0] init = {{(n-2){1'b0}}, 2'b10}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cke,
    output logic [n-1:0] lfsr
);
    import lfsr_package::*;

    localparam logic [n-1:0] FB_MASK = LFSR_TAPS[n][n-1:0];

    logic [n-1:0] lfsr_q;
    logic [n-1:0] lfsr_d;

    // Next state: shift in the parity of the tapped bits when enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (cke) begin
            lfsr_d = {lfsr_q[n-2:0], ^(lfsr_q & FB_MASK)};
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= init;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/lfsr_req_arbiter.sv
// Round-robin arbiter sharing one LFSR among N_REQ requesters.
// After reset or resync the LFSR free-runs WARMUP steps, then each grant
// steps it once and the winner gets a one-cycle ack with the new state.
// Optional feature macro: LFSR_ARB_GRANT_CNT_EN adds a 32-bit grant counter.
module lfsr_req_arbiter #(
    parameter int           N_REQ  = 4,
    parameter int           n      = 16,
    parameter logic [n-1:0] init   = {{(n-2){1'b0}}, 2'b10},
    parameter int           WARMUP = 32
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_req_arbiter_if.slave  bus
);
    import lfsr_package::*;

    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] WARM_LAST = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;
    localparam lfsr_package::lfsr_arb_state_t START_STATE =
        (WARMUP == 0) ? lfsr_package::SERVE : lfsr_package::WARMUP;

    if (!lfsr_width_ok(n)) begin : g_bad_width
        $error("lfsr_req_arbiter: no LFSR tap table entry for width %0d", n);
    end
    if (N_REQ < 1) begin : g_bad_nreq
        $error("lfsr_req_arbiter: N_REQ must be at least 1");
    end
    if (WARMUP < 0) begin : g_bad_warmup
        $error("lfsr_req_arbiter: WARMUP must not be negative");
    end
    if (init == '0) begin : g_bad_init
        $error("lfsr_req_arbiter: LFSR seed must be non-zero");
    end

    // First eligible index at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] elig,
                                            input logic [PW-1:0]    ptr);
        logic          found;
        logic [PW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && elig[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
        return {found, idx};
    endfunction

    lfsr_package::lfsr_arb_state_t state_q, state_d;
    logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [N_REQ-1:0] ack_q, ack_d;

    logic [N_REQ-1:0] elig;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic             grant_vld;
    logic             cke;
    logic             lfsr_rst;
    logic [n-1:0]     lfsr_state;

    // State, warm-up counter, pointer and ack registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= START_STATE;
            warm_cnt_q <= '0;
            rr_q       <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
        end
    end

    // Next state: count warm-up steps, resync restarts the warm-up.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        if (bus.resync) begin
            state_d    = START_STATE;
            warm_cnt_d = '0;
        end else if (state_q == lfsr_package::WARMUP) begin
            if (warm_cnt_q == WARM_LAST) begin
                state_d    = lfsr_package::SERVE;
                warm_cnt_d = '0;
            end else begin
                warm_cnt_d = warm_cnt_q + 1'b1;
            end
        end
    end

    // Outputs: grant selection, LFSR enable, next ack and pointer.
    always_comb begin
        elig                   = bus.req & ~ack_q;
        {pick_found, pick_idx} = rr_pick(elig, rr_q);
        grant_vld              = (state_q == lfsr_package::SERVE) && !bus.resync && pick_found;
        cke                    = ((state_q == lfsr_package::WARMUP) && !bus.resync) || grant_vld;
        ack_d                  = '0;
        rr_d                   = rr_q;
        if (grant_vld) begin
            ack_d[pick_idx] = 1'b1;
            rr_d            = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
    end

    // Reset and resync both reseed the source; reset acts immediately.
    assign lfsr_rst = ~rst | bus.resync;

    lfsr_cke #(
        .n    (n),
        .init (init)
    ) u_lfsr (
        .clk  (clk),
        .rst  (lfsr_rst),
        .cke  (cke),
        .lfsr (lfsr_state)
    );

    assign bus.ack  = ack_q;
    assign bus.data = lfsr_state;
    assign bus.busy = (state_q == lfsr_package::WARMUP);

`ifdef LFSR_ARB_GRANT_CNT_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;

    // Total grant count, wraps naturally; untouched by resync.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (grant_vld) begin
            grant_cnt_d = grant_cnt_q + 32'd1;
        end
    end

    // Grant counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Bench for lfsr_req_arbiter: directed scenarios plus randomized requests
// and resync pulses against a behavioural model; a second instance built
// with WARMUP=0 covers the asynchronous reset in the serving state.
module tb_lfsr_req_arbiter;

    localparam int          NR     = 4;
    localparam int          W      = 16;
    localparam int          WARM   = 4;
    localparam logic [15:0] SEED   = 16'h0002;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    lfsr_req_arbiter_if #(.N_REQ(NR), .n(W)) bus_a ();
    lfsr_req_arbiter_if #(.N_REQ(NR), .n(W)) bus_b ();

    lfsr_req_arbiter #(.N_REQ(NR), .n(W), .init(SEED), .WARMUP(WARM)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    lfsr_req_arbiter #(.N_REQ(NR), .n(W), .init(SEED), .WARMUP(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of instance A
    logic [15:0] m_lfsr;
    int          m_warm_left;
    bit          m_serving;
    logic [3:0]  m_ack;
    int          m_ptr;
    logic [31:0] m_gcnt;

    // Sequence a_k = a_{k-2} ^ a_{k-3} ^ a_{k-5} ^ a_{k-16}, newest bit at bit 0
    // (characteristic polynomial x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[1] ^ s[2] ^ s[4] ^ s[15];
        return {s[14:0], fb};
    endfunction

    task automatic model_reset();
        m_lfsr      = SEED;
        m_warm_left = WARM;
        m_serving   = (WARM == 0);
        m_ack       = '0;
        m_ptr       = 0;
        m_gcnt      = '0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic resync);
        logic [3:0] elig;
        int         g;
        int         idx;
        if (resync) begin
            m_lfsr      = SEED;
            m_warm_left = WARM;
            m_serving   = (WARM == 0);
            m_ack       = '0;
        end else if (!m_serving) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_warm_left--;
            if (m_warm_left == 0) m_serving = 1'b1;
            m_ack = '0;
        end else begin
            elig = req & ~m_ack;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && elig[idx]) g = idx;
            end
            if (g >= 0) begin
                m_lfsr = lfsr_next(m_lfsr);
                m_ack  = 4'b0001 << g;
                m_ptr  = (g + 1) % NR;
                m_gcnt = m_gcnt + 32'd1;
            end else begin
                m_ack = '0;
            end
        end
    endtask

    task automatic sample_a();
        @(negedge clk);
        check("a_ack", bus_a.ack, m_ack);
        check("a_busy", bus_a.busy, !m_serving);
        check("a_ack_onehot0", $onehot0(bus_a.ack), 1);
        if (!bus_a.resync) check("a_data", bus_a.data, m_lfsr);
`ifdef LFSR_ARB_GRANT_CNT_EN
        check("a_grant_cnt", bus_a.grant_cnt, m_gcnt);
`endif
    endtask

    task automatic edge_a();
        @(posedge clk);
        if (rst_a) model_edge(bus_a.req, bus_a.resync);
        #1;
    endtask

    logic [15:0] warm_tbl [0:5];
    logic [3:0]  r;
    int          busy_fall;
    int          first_ack;

    initial begin
        warm_tbl[0] = 16'h0002; warm_tbl[1] = 16'h0005; warm_tbl[2] = 16'h000B;
        warm_tbl[3] = 16'h0017; warm_tbl[4] = 16'h002F; warm_tbl[5] = 16'h002F;

        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.req = '0; bus_a.resync = 1'b0;
        bus_b.req = '0; bus_b.resync = 1'b0;
        model_reset();

        // Reset state
        #1;
        repeat (2) begin sample_a(); edge_a(); end
        rst_a = 1'b1;

        // Warm-up sequence, no requests
        for (int i = 0; i < 10; i++) begin
            sample_a();
            check("warm_data", bus_a.data, warm_tbl[(i < 5) ? i : 5]);
            check("warm_busy", bus_a.busy, (i < 4) ? 1'b1 : 1'b0);
            edge_a();
        end

        // Single requester held: served every other cycle
        bus_a.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            sample_a();
            check("single_ack", bus_a.ack, (i % 2 == 1) ? 4'b0001 : 4'b0000);
            if (i == 1) check("single_data", bus_a.data, 16'h005E);
            edge_a();
        end
        bus_a.req = '0;
        repeat (2) begin sample_a(); edge_a(); end

        // All requesters held: one ack every cycle
        bus_a.req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            sample_a();
            if (i > 0) check("all_ack_every_cycle", $countones(bus_a.ack), 1);
            edge_a();
        end
        bus_a.req = '0;
        repeat (2) begin sample_a(); edge_a(); end

        // Request raised during warm-up: ack one cycle after busy falls
        bus_a.resync = 1'b1;
        sample_a(); edge_a();
        bus_a.resync = 1'b0;
        bus_a.req = 4'b0100;
        busy_fall = -1; first_ack = -1;
        for (int i = 0; i < 10; i++) begin
            sample_a();
            if (busy_fall < 0 && !bus_a.busy) busy_fall = i;
            if (first_ack < 0 && bus_a.ack != 0) first_ack = i;
            edge_a();
            if (m_ack[2]) bus_a.req = '0;
        end
        check("warm_req_latency", first_ack - busy_fall, 1);
        bus_a.req = '0;
        repeat (2) begin sample_a(); edge_a(); end

        // Resync in the cycle after a grant: ack still delivered, warm-up repeats
        bus_a.req = 4'b0001;
        for (int i = 0; i < 4 && m_ack == 0; i++) begin sample_a(); edge_a(); end
        bus_a.resync = 1'b1;
        bus_a.req = '0;
        sample_a();
        check("resync_ack_kept", bus_a.ack, 4'b0001);
        edge_a();
        bus_a.resync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_a();
            check("resync_warm_data", bus_a.data, warm_tbl[i]);
            check("resync_warm_busy", bus_a.busy, (i < 4) ? 1'b1 : 1'b0);
            edge_a();
        end

        // Randomized requests and resync pulses
        r = '0;
        for (int c = 0; c < 400; c++) begin
            sample_a();
            edge_a();
            bus_a.resync = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NR; i++) begin
                if (m_ack[i]) r[i] = 1'($urandom_range(0, 1));
                else if (!r[i]) r[i] = ($urandom_range(0, 2) == 0);
            end
            bus_a.req = r;
        end
        bus_a.resync = 1'b0;
        bus_a.req = '0;

        // Instance B (WARMUP=0): serve from reset, async reset mid-serve
        @(posedge clk); #1;
        rst_b = 1'b1;
        bus_b.req = 4'b1111;
        @(negedge clk);
        check("b_rel_ack", bus_b.ack, 4'b0000);
        check("b_rel_busy", bus_b.busy, 1'b0);
        check("b_rel_data", bus_b.data, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_rr_ack", bus_b.ack, 4'b0001 << i);
            check("b_rr_data", bus_b.data, warm_tbl[i + 1]);
        end
`ifdef LFSR_ARB_GRANT_CNT_EN
        check("b_grant_cnt", bus_b.grant_cnt, 32'd4);
`endif
        @(posedge clk); #2;
        rst_b = 1'b0;
        #1;
        check("b_async_ack", bus_b.ack, 4'b0000);
        check("b_async_data", bus_b.data, 16'h0002);
`ifdef LFSR_ARB_GRANT_CNT_EN
        check("b_async_grant_cnt", bus_b.grant_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_post_rst_ack", bus_b.ack, 4'b0001);
        check("b_post_rst_data", bus_b.data, 16'h0005);
        bus_b.req = '0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
